// File: rtl/wavetable_sequencer_if.sv
// wavetable_sequencer_if: configuration write handshake from the patch loader.
interface wavetable_sequencer_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_addr;
    logic [7:0] cfg_left;
    logic [7:0] cfg_right;
    logic [7:0] cfg_factor;
    logic       cfg_is_pure;
    modport master (output cfg_valid, cfg_addr, cfg_left, cfg_right, cfg_factor, cfg_is_pure, input cfg_ready);
    modport slave  (input cfg_valid, cfg_addr, cfg_left, cfg_right, cfg_factor, cfg_is_pure, output cfg_ready);
endinterface

// File: rtl/wavetable_sequencer.sv
// wavetable_sequencer: per-sample voice scan of the wavetable RAM with interleaved config writes.
module wavetable_sequencer #(
    parameter int VOICES    = 8,
    parameter int RAM_DEPTH = 61
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_tick,
    input  logic [6*VOICES-1:0] voice_idx,
    wavetable_sequencer_if.slave cfg,
    output logic                ram_re,
    output logic [5:0]          ram_addr_r,
    input  logic [7:0]          ram_left_r,
    input  logic [7:0]          ram_right_r,
    input  logic [7:0]          ram_factor_r,
    input  logic                ram_is_pure_r,
    output logic                ram_we,
    output logic [5:0]          ram_addr_w,
    output logic [7:0]          ram_left_w,
    output logic [7:0]          ram_right_w,
    output logic [7:0]          ram_factor_w,
    output logic                ram_is_pure_w,
    output logic                out_valid,
    output logic [3:0]          out_voice,
    output logic [7:0]          out_left,
    output logic [7:0]          out_right,
    output logic [7:0]          out_factor,
    output logic                out_is_pure,
    output logic                frame_done,
    output logic                busy,
    output logic                overrun,
    output logic                cfg_err,
    input  logic                status_clr
);
    typedef enum logic [1:0] {IDLE, WRITE, SCAN, DRAIN} state_t;
    localparam logic [6:0] DEPTH = 7'(RAM_DEPTH);
    localparam logic [3:0] LAST  = 4'(VOICES - 1);

    state_t              state;
    logic [3:0]          cnt;
    logic                armed;
    logic [6*VOICES-1:0] snap;
    logic                p_valid;
    logic                p_zero;
    logic [3:0]          p_voice;
    logic [3:0]          nxt;
    logic [5:0]          nxt_idx;
    logic                accept;
    logic                tick_go;

    function automatic logic in_range(input logic [5:0] a);
        return {1'b0, a} < DEPTH;
    endfunction

    // armed keeps cfg_ready low while reset is held
    assign cfg.cfg_ready = armed & (state == IDLE) & ~sample_tick;
    assign accept  = cfg.cfg_valid & cfg.cfg_ready;
    assign tick_go = sample_tick & ((state == IDLE) | (state == WRITE));
    assign nxt     = cnt + 4'd1;
    assign nxt_idx = snap[6*nxt +: 6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            armed         <= 1'b0;
            snap          <= '0;
            p_valid       <= 1'b0;
            p_zero        <= 1'b0;
            p_voice       <= '0;
            ram_re        <= 1'b0;
            ram_addr_r    <= '0;
            ram_we        <= 1'b0;
            ram_addr_w    <= '0;
            ram_left_w    <= '0;
            ram_right_w   <= '0;
            ram_factor_w  <= '0;
            ram_is_pure_w <= 1'b0;
            out_valid     <= 1'b0;
            out_voice     <= '0;
            out_left      <= '0;
            out_right     <= '0;
            out_factor    <= '0;
            out_is_pure   <= 1'b0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            armed       <= 1'b1;
            ram_we      <= 1'b0;
            p_valid     <= state == SCAN;
            p_zero      <= ~ram_re;
            p_voice     <= cnt;
            out_valid   <= p_valid;
            out_voice   <= p_valid ? p_voice : '0;
            out_left    <= (p_valid & ~p_zero) ? ram_left_r : '0;
            out_right   <= (p_valid & ~p_zero) ? ram_right_r : '0;
            out_factor  <= (p_valid & ~p_zero) ? ram_factor_r : '0;
            out_is_pure <= p_valid & ~p_zero & ram_is_pure_r;
            frame_done  <= p_valid & (p_voice == LAST);
            overrun     <= ~status_clr & (overrun | (sample_tick & ((state == SCAN) | (state == DRAIN))));
            cfg_err     <= ~status_clr & (cfg_err | (accept & ~in_range(cfg.cfg_addr)));
            // a tick landing in WRITE is served as soon as WRITE ends
            if (tick_go) begin
                state      <= SCAN;
                busy       <= 1'b1;
                snap       <= voice_idx;
                cnt        <= '0;
                ram_re     <= in_range(voice_idx[5:0]);
                ram_addr_r <= voice_idx[5:0];
            end else if (accept) begin
                state         <= WRITE;
                busy          <= 1'b1;
                ram_we        <= in_range(cfg.cfg_addr);
                ram_addr_w    <= cfg.cfg_addr;
                ram_left_w    <= cfg.cfg_left;
                ram_right_w   <= cfg.cfg_right;
                ram_factor_w  <= cfg.cfg_factor;
                ram_is_pure_w <= cfg.cfg_is_pure;
            end else if (state == WRITE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (state == SCAN) begin
                if (cnt == LAST) begin
                    state  <= DRAIN;
                    cnt    <= '0;
                    ram_re <= 1'b0;
                end else begin
                    cnt        <= nxt;
                    ram_re     <= in_range(nxt_idx);
                    ram_addr_r <= nxt_idx;
                end
            end else if (state == DRAIN) begin
                cnt <= nxt;
                if (cnt == 4'd1) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_wavetable_sequencer.sv
// tb_wavetable_sequencer: directed and randomized scans checked against a shadow wavetable model.
module tb_wavetable_sequencer;
    localparam int V = 8;
    localparam int D = 61;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sample_tick = 1'b0;
    logic         status_clr = 1'b0;
    logic [6*V-1:0] voice_idx = '0;
    logic         ram_re, ram_we, ram_is_pure_r, ram_is_pure_w;
    logic [5:0]   ram_addr_r, ram_addr_w;
    logic [7:0]   ram_left_r, ram_right_r, ram_factor_r;
    logic [7:0]   ram_left_w, ram_right_w, ram_factor_w;
    logic         out_valid, out_is_pure, frame_done, busy, overrun, cfg_err;
    logic [3:0]   out_voice;
    logic [7:0]   out_left, out_right, out_factor;

    wavetable_sequencer_if cfg_if();

    wavetable_sequencer #(.VOICES(V), .RAM_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .voice_idx(voice_idx), .cfg(cfg_if),
        .ram_re(ram_re), .ram_addr_r(ram_addr_r), .ram_left_r(ram_left_r), .ram_right_r(ram_right_r),
        .ram_factor_r(ram_factor_r), .ram_is_pure_r(ram_is_pure_r), .ram_we(ram_we), .ram_addr_w(ram_addr_w),
        .ram_left_w(ram_left_w), .ram_right_w(ram_right_w), .ram_factor_w(ram_factor_w),
        .ram_is_pure_w(ram_is_pure_w), .out_valid(out_valid), .out_voice(out_voice), .out_left(out_left),
        .out_right(out_right), .out_factor(out_factor), .out_is_pure(out_is_pure), .frame_done(frame_done),
        .busy(busy), .overrun(overrun), .cfg_err(cfg_err), .status_clr(status_clr)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle read latency; entries past the valid range hold junk
    logic [24:0] mem [64];
    logic [24:0] rd = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr_w] <= {ram_is_pure_w, ram_factor_w, ram_right_w, ram_left_w};
        if (ram_re) rd <= mem[ram_addr_r];
    end
    assign {ram_is_pure_r, ram_factor_r, ram_right_r, ram_left_r} = rd;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [28:0] obs [$];
    int obs_cyc [$];
    int re_cyc [$];
    int fd_cnt = 0, fd_last = -1, fd_cyc = -1, we_cnt = 0, both_cnt = 0;
    always @(negedge clk) begin
        if (out_valid) begin
            obs.push_back({out_voice, out_is_pure, out_factor, out_right, out_left});
            obs_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_last = int'(out_voice);
            fd_cyc = cyc;
        end
        if (ram_we) we_cnt++;
        if (ram_re && ram_we) both_cnt++;
        if (ram_re) re_cyc.push_back(cyc);
    end

    logic [24:0] sh [D];
    logic [28:0] exp_q [$];
    logic [15:0] exp_mask;
    int total = 0, bad = 0;
    int t0 = 0, obs_base = 0, fd_base = 0, re_base = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_frame();
        obs_base = obs.size();
        fd_base = fd_cnt;
        re_base = re_cyc.size();
        exp_q.delete();
        exp_mask = '0;
        for (int k = 0; k < V; k++) begin
            logic [5:0] idx;
            idx = voice_idx[6*k +: 6];
            exp_mask[k] = int'(idx) < D;
            exp_q.push_back({4'(k), (int'(idx) < D) ? sh[idx] : 25'h0});
        end
    endtask

    task automatic do_tick();
        start_frame();
        @(posedge clk); #1 sample_tick = 1'b1;
        t0 = cyc + 1;
        @(posedge clk); #1 sample_tick = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        int n = 0;
        logic [15:0] m = '0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_to"}, 32'(n >= 60), 0);
        chk({tag, "_busyfall"}, cyc, t0 + V + 2);
        chk({tag, "_n"}, obs.size() - obs_base, V);
        for (int k = 0; k < V; k++)
            if (obs_base + k < obs.size()) chk($sformatf("%s_v%0d", tag, k), 32'(obs[obs_base + k]), 32'(exp_q[k]));
        if (obs.size() > obs_base) chk({tag, "_lat"}, obs_cyc[obs_base], t0 + 2);
        chk({tag, "_fdn"}, fd_cnt - fd_base, 1);
        chk({tag, "_fdv"}, fd_last, V - 1);
        chk({tag, "_fdc"}, fd_cyc, t0 + V + 1);
        for (int i = re_base; i < re_cyc.size(); i++) begin
            int d;
            d = re_cyc[i] - t0;
            if (d >= 0 && d < 15) m[d] = 1'b1;
            else m[15] = 1'b1;
        end
        chk({tag, "_remask"}, 32'(m), 32'(exp_mask));
    endtask

    task automatic wait_accept(input string tag, output int wc);
        int n = 0;
        while (!cfg_if.cfg_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_acc_to"}, 32'(n >= 40), 0);
        wc = cyc + 1;
        @(posedge clk); #1 cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic drive_cfg(input logic [5:0] a, input logic [24:0] dat);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr = a;
        {cfg_if.cfg_is_pure, cfg_if.cfg_factor, cfg_if.cfg_right, cfg_if.cfg_left} = dat;
    endtask

    task automatic do_write(input string tag, input logic [5:0] a, input logic [24:0] dat, input bit tick);
        int wc;
        @(posedge clk); #1 drive_cfg(a, dat);
        wait_accept(tag, wc);
        if (int'(a) < D) sh[a] = dat;
        if (tick) begin
            start_frame();
            sample_tick = 1'b1;
            t0 = cyc + 1;
            @(posedge clk); #1 sample_tick = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 status_clr = 1'b1;
        @(posedge clk); #1 status_clr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, wc, ob, fb;
        bit exp_err;
        for (int a = 0; a < 64; a++) mem[a] = (a < D) ? {1'b0, 8'(a), 8'(a), 8'(a)} : 25'h1ABCDEF;
        for (int a = 0; a < D; a++) sh[a] = {1'b0, 8'(a), 8'(a), 8'(a)};
        drive_cfg(6'd0, 25'h0);
        cfg_if.cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_re", ram_re, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_ready", cfg_if.cfg_ready, 0);
        chk("rst_flags", {overrun, cfg_err, frame_done}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", cfg_if.cfg_ready, 1);

        for (int k = 0; k < V; k++) voice_idx[6*k +: 6] = (k < 7) ? 6'(7 * k) : 6'd60;
        do_tick();
        finish_frame("ramp");

        voice_idx[5:0] = 6'd5;
        wb = we_cnt;
        do_write("wr5", 6'd5, {1'b1, 8'hAA, 8'hBB, 8'hCC}, 1'b0);
        repeat (2) @(negedge clk);
        chk("wr5_we", we_cnt - wb, 1);
        do_tick();
        finish_frame("wr5");
        chk("wr5_data", 32'(obs[obs_base][24:0]), 32'h1AABBCC);

        start_frame();
        @(posedge clk); #1 sample_tick = 1'b1;
        drive_cfg(6'd9, 25'h0123456);
        t0 = cyc + 1;
        @(negedge clk);
        chk("sim_ready", cfg_if.cfg_ready, 0);
        @(posedge clk); #1 sample_tick = 1'b0;
        finish_frame("sim");
        wait_accept("sim", wc);
        sh[9] = 25'h0123456;
        chk("sim_wc", wc, t0 + V + 3);

        voice_idx[6*2 +: 6] = 6'd12;
        do_write("pend", 6'd12, 25'h1F00D42, 1'b1);
        repeat (2) @(negedge clk);
        chk("pend_ovr0", overrun, 0);
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        finish_frame("pend");
        chk("pend_ovr1", overrun, 1);
        pulse_clr();
        @(negedge clk);
        chk("pend_clr", overrun, 0);

        voice_idx[6*3 +: 6] = 6'd61;
        wb = we_cnt;
        do_write("oor", 6'd63, 25'h1555555, 1'b0);
        repeat (2) @(negedge clk);
        chk("oor_we", we_cnt - wb, 0);
        chk("oor_err", cfg_err, 1);
        do_tick();
        finish_frame("oor");
        chk("oor_v3", 32'(obs[obs_base + 3]), 32'({4'd3, 25'h0}));
        pulse_clr();
        @(negedge clk);
        chk("oor_clr", cfg_err, 0);

        do_tick();
        sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        while (cyc < t0 + 3) @(negedge clk);
        chk("mid_ovr", overrun, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {out_valid, frame_done, ram_re, ram_we, busy}, 0);
        chk("mid_rst_flags", {overrun, cfg_err, cfg_if.cfg_ready}, 0);
        ob = obs.size();
        fb = fd_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_rst_noout", obs.size() - ob, 0);
        chk("mid_rst_nofd", fd_cnt - fb, 0);
        do_tick();
        finish_frame("post_rst");

        exp_err = 1'b0;
        for (int it = 0; it < 16; it++) begin
            for (int k = 0; k < V; k++) voice_idx[6*k +: 6] = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                logic [5:0] a;
                a = 6'($urandom_range(0, 63));
                if (int'(a) >= D) exp_err = 1'b1;
                do_write("rnd", a, 25'($urandom), 1'b0);
            end
            do_tick();
            voice_idx = {$urandom, $urandom};
            finish_frame($sformatf("rnd%0d", it));
            chk("rnd_err", cfg_err, 32'(exp_err));
            chk("rnd_ovr", overrun, 0);
            pulse_clr();
            exp_err = 1'b0;
        end

        chk("re_we_excl", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
